mag_power_ctrl: RTL and testbench

MAG_POWER_CTRL -- requirements
Module: mag_power_ctrl

---
 rtl/mag_pkg.sv | 15 +
 rtl/mag_power_ctrl_if.sv | 23 ++
 rtl/mag_chan.sv | 85 ++++++++
 rtl/mag_power_ctrl.sv | 86 ++++++++
 tb/tb_mag_power_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mag_pkg.sv
// Shared types and default constants for the magnetron power controller.
package mag_pkg;

   // Default duty-window length (slots) and slot length (clock cycles)
   localparam int MAX_LVL_DEF  = 10;
   localparam int SLOT_CYC_DEF = 4;

   // Per-channel run state
   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } mag_state_e;

endpackage

// File: rtl/mag_power_ctrl_if.sv
// Control/status bundle between the oven controller and mag_power_ctrl.
interface mag_power_ctrl_if #(
   parameter int N_CH  = 2,
   parameter int LVL_W = 4
);
   logic [N_CH-1:0]       set;
   logic [N_CH-1:0]       reset;
   logic                  door_open;
   logic [N_CH*LVL_W-1:0] level;
   logic [N_CH-1:0]       armed;
   logic [N_CH-1:0]       mag_on;
   logic                  fault;

   modport master (
      output set, reset, door_open, level,
      input  armed, mag_on, fault
   );

   modport slave (
      input  set, reset, door_open, level,
      output armed, mag_on, fault
   );
endinterface

// File: rtl/mag_chan.sv
// One magnetron channel: OFF/RUN/PAUSE state machine, power-level latch and
// duty-gated drive output.
module mag_chan
   import mag_pkg::*;
#(
   parameter int LVL_W   = 4,
   parameter int MAX_LVL = MAX_LVL_DEF,
   parameter int RST_DOM = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set,
   input  logic             reset,
   input  logic             door_open,
   input  logic             door_rise,
   input  logic             slot_wrap,
   input  logic [LVL_W-1:0] slot_idx,
   input  logic [LVL_W-1:0] level,
   output logic             armed,
   output logic             mag_on
);

   localparam logic [LVL_W-1:0] MAX_L = LVL_W'(MAX_LVL);

   mag_state_e       state_q, state_d;
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic             armed_q, armed_d;
   logic             mag_on_q, mag_on_d;
   logic             set_eff, rst_eff;

   // Resolve a simultaneous set/reset to a single request
   always_comb begin
      set_eff = set;
      rst_eff = reset;
      if (set && reset) begin
         set_eff = (RST_DOM == 0);
         rst_eff = (RST_DOM != 0);
      end
   end

   // Next state, level latch and duty gating
   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      case (state_q)
         ST_OFF:   if (set_eff && !door_open) state_d = ST_RUN;
         ST_RUN: begin
            if (rst_eff)        state_d = ST_OFF;
            else if (door_open) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (rst_eff)                      state_d = ST_OFF;
            else if (set_eff && !door_open)   state_d = ST_RUN;
         end
         default:  state_d = ST_OFF;
      endcase
      // Level is only sampled at RUN entry and at window start so a change
      // never splits a duty window
      if ((state_d == ST_RUN && state_q != ST_RUN) || slot_wrap)
         lvl_d = (level > MAX_L) ? MAX_L : level;
      armed_d  = (state_d != ST_OFF);
      // Drive follows the current state/slot one cycle later; an opening
      // door kills it immediately even though the FSM still reads RUN
      mag_on_d = !door_rise && (state_q == ST_RUN) && (slot_idx < lvl_q);
   end

   // State machine and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_OFF;
         lvl_q    <= '0;
         armed_q  <= 1'b0;
         mag_on_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         lvl_q    <= lvl_d;
         armed_q  <= armed_d;
         mag_on_q <= mag_on_d;
      end
   end

   assign armed  = armed_q;
   assign mag_on = mag_on_q;

endmodule

// File: rtl/mag_power_ctrl.sv
// Multi-channel magnetron power controller: shared slot counter, door
// interlock, sticky fault flag and N_CH independent duty-cycled channels.
module mag_power_ctrl
   import mag_pkg::*;
#(
   parameter int N_CH     = 2,
   parameter int LVL_W    = 4,
   parameter int MAX_LVL  = MAX_LVL_DEF,
   parameter int SLOT_CYC = SLOT_CYC_DEF,
   parameter int RST_DOM  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   mag_power_ctrl_if.slave  bus
);

   localparam int               CYC_W     = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(SLOT_CYC - 1);
   localparam logic [LVL_W-1:0] SLOT_LAST = LVL_W'(MAX_LVL - 1);

   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [LVL_W-1:0] slot_q, slot_d;
   logic             door_q, door_d;
   logic             fault_q, fault_d;
   logic             slot_wrap, door_rise;
   logic [N_CH-1:0]  armed_w, mag_on_w;

   assign slot_wrap = (cyc_q == CYC_LAST) && (slot_q == SLOT_LAST);
   assign door_rise = bus.door_open && !door_q;

   // Free-running slot counter, door edge history and fault flag
   always_comb begin
      cyc_d  = cyc_q + 1'b1;
      slot_d = slot_q;
      if (cyc_q == CYC_LAST) begin
         cyc_d  = '0;
         slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      end
      door_d  = bus.door_open;
      fault_d = fault_q;
      if (|bus.set && bus.door_open)
         fault_d = 1'b1;
      else if (!bus.door_open && &bus.reset)
         fault_d = 1'b0;
   end

   // Shared state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q   <= '0;
         slot_q  <= '0;
         door_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         cyc_q   <= cyc_d;
         slot_q  <= slot_d;
         door_q  <= door_d;
         fault_q <= fault_d;
      end
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
      mag_chan #(
         .LVL_W   (LVL_W),
         .MAX_LVL (MAX_LVL),
         .RST_DOM (RST_DOM)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .set       (bus.set[ch]),
         .reset     (bus.reset[ch]),
         .door_open (bus.door_open),
         .door_rise (door_rise),
         .slot_wrap (slot_wrap),
         .slot_idx  (slot_q),
         .level     (bus.level[ch*LVL_W +: LVL_W]),
         .armed     (armed_w[ch]),
         .mag_on    (mag_on_w[ch])
      );
   end

   assign bus.armed  = armed_w;
   assign bus.mag_on = mag_on_w;
   assign bus.fault  = fault_q;

endmodule

// File: tb/tb_mag_power_ctrl.sv
// Scoreboard bench: two DUTs (reset-dominant and set-dominant) share stimulus;
// a behavioural model pushes expected outputs, a monitor pops and compares.
module tb_mag_power_ctrl;

   localparam int N_CH = 2, LVL_W = 4, MAX_LVL = 10, SLOT_CYC = 4;
   localparam int M_OFF = 0, M_RUN = 1, M_PAUSE = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mag_power_ctrl_if #(.N_CH(N_CH), .LVL_W(LVL_W)) bus1 ();
   mag_power_ctrl_if #(.N_CH(N_CH), .LVL_W(LVL_W)) bus0 ();

   mag_power_ctrl #(.N_CH(N_CH), .LVL_W(LVL_W), .MAX_LVL(MAX_LVL),
                    .SLOT_CYC(SLOT_CYC), .RST_DOM(1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   mag_power_ctrl #(.N_CH(N_CH), .LVL_W(LVL_W), .MAX_LVL(MAX_LVL),
                    .SLOT_CYC(SLOT_CYC), .RST_DOM(0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

   typedef struct packed {
      logic            f;
      logic [N_CH-1:0] mag;
      logic [N_CH-1:0] arm;
   } exp_t;
   typedef struct packed {
      exp_t d1;
      exp_t d0;
   } pair_t;

   pair_t sb_q[$];
   int    n_cmp = 0, n_err = 0;

   // behavioural model: index [dom] where dom is the RST_DOM value
   int st [2][N_CH];
   int lvl[2][N_CH];
   bit mag[2][N_CH];
   bit mflt;
   bit door_prev;
   int ncyc;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < N_CH; c++) begin
            st[d][c] = M_OFF; lvl[d][c] = 0; mag[d][c] = 0;
         end
      mflt = 0; door_prev = 0; ncyc = 0;
   endtask

   // One clock edge of the intended behaviour, from the requirements' rules
   task automatic model_step(input logic [1:0] s, input logic [1:0] r, input logic door,
                             input int l0, input int l1, output pair_t p);
      int  slot_b, lv, ns;
      bit  wrap, rise, si, ri;
      exp_t e[2];
      slot_b = (ncyc / SLOT_CYC) % MAX_LVL;
      wrap   = ((ncyc + 1) % (SLOT_CYC * MAX_LVL)) == 0;
      rise   = door && !door_prev;
      if (|s && door) mflt = 1;
      else if (!door && &r) mflt = 0;
      for (int d = 0; d < 2; d++) begin
         e[d] = '0;
         for (int c = 0; c < N_CH; c++) begin
            si = s[c]; ri = r[c];
            if (si && ri) begin
               if (d == 1) si = 0; else ri = 0;
            end
            mag[d][c] = !rise && st[d][c] == M_RUN && slot_b < lvl[d][c];
            ns = st[d][c];
            if (st[d][c] == M_OFF) begin
               if (si && !door) ns = M_RUN;
            end else if (st[d][c] == M_RUN) begin
               if (ri) ns = M_OFF; else if (door) ns = M_PAUSE;
            end else begin
               if (ri) ns = M_OFF; else if (si && !door) ns = M_RUN;
            end
            lv = (c == 0) ? l0 : l1;
            if ((ns == M_RUN && st[d][c] != M_RUN) || wrap)
               lvl[d][c] = (lv > MAX_LVL) ? MAX_LVL : lv;
            st[d][c]     = ns;
            e[d].arm[c]  = (ns != M_OFF);
            e[d].mag[c]  = mag[d][c];
         end
         e[d].f = mflt;
      end
      door_prev = door;
      ncyc++;
      p.d1 = e[1];
      p.d0 = e[0];
   endtask

   task automatic drive(input logic [1:0] s, input logic [1:0] r, input logic door,
                        input int l0, input int l1);
      logic [7:0] lv;
      pair_t p;
      @(negedge clk);
      lv = {l1[3:0], l0[3:0]};
      bus1.set = s; bus1.reset = r; bus1.door_open = door; bus1.level = lv;
      bus0.set = s; bus0.reset = r; bus0.door_open = door; bus0.level = lv;
      model_step(s, r, door, l0, l1, p);
      sb_q.push_back(p);
   endtask

   task automatic idle(input int n, input logic door, input int l0, input int l1);
      for (int i = 0; i < n; i++) drive(2'b00, 2'b00, door, l0, l1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " d1 outs"}, 8'({bus1.fault, bus1.mag_on, bus1.armed}), 8'h00);
      check({tag, " d0 outs"}, 8'({bus0.fault, bus0.mag_on, bus0.armed}), 8'h00);
   endtask

   // Monitor: compare registered outputs shortly after each edge
   initial begin
      pair_t p;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            check("d1.armed",  8'(bus1.armed),  8'(p.d1.arm));
            check("d1.mag_on", 8'(bus1.mag_on), 8'(p.d1.mag));
            check("d1.fault",  8'(bus1.fault),  8'(p.d1.f));
            check("d0.armed",  8'(bus0.armed),  8'(p.d0.arm));
            check("d0.mag_on", 8'(bus0.mag_on), 8'(p.d0.mag));
            check("d0.fault",  8'(bus0.fault),  8'(p.d0.f));
         end
      end
   end

   initial begin
      logic [1:0] rs, rr;
      logic       rd;
      int         rl0, rl1;
      bus1.set = '0; bus1.reset = '0; bus1.door_open = 1'b0; bus1.level = '0;
      bus0.set = '0; bus0.reset = '0; bus0.door_open = 1'b0; bus0.level = '0;
      model_reset();
      #2 check_all_zero("reset");
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // idle, then channel 0 at level 5 for two full windows
      idle(3, 0, 5, 0);
      drive(2'b01, 2'b00, 0, 5, 0);
      idle(80, 0, 5, 0);

      // stop, then simultaneous set+reset: dominance differs per DUT
      drive(2'b00, 2'b01, 0, 5, 0);
      idle(2, 0, 5, 0);
      drive(2'b01, 2'b01, 0, 5, 0);
      idle(6, 0, 5, 0);
      drive(2'b00, 2'b01, 0, 5, 0);

      // full power, door opens (pause), closes (stays off), set resumes
      drive(2'b01, 2'b00, 0, 10, 0);
      idle(12, 0, 10, 0);
      idle(5, 1, 10, 0);
      idle(6, 0, 10, 0);
      drive(2'b01, 2'b00, 0, 10, 0);
      idle(8, 0, 10, 0);

      // set with the door open raises fault; only door closed + reset all clears it
      drive(2'b00, 2'b11, 0, 0, 0);
      drive(2'b10, 2'b00, 1, 0, 0);
      idle(3, 1, 0, 0);
      drive(2'b00, 2'b01, 0, 0, 0);
      drive(2'b00, 2'b11, 1, 0, 0);
      idle(2, 0, 0, 0);
      drive(2'b00, 2'b11, 0, 0, 0);
      idle(2, 0, 0, 0);

      // clamped level 15 on ch1, level 0 on ch0, then mid-window level change
      drive(2'b11, 2'b00, 0, 0, 15);
      idle(45, 0, 0, 15);
      idle(10, 0, 3, 15);
      idle(10, 0, 3, 2);
      idle(50, 0, 8, 2);

      // randomized traffic
      rd = 0; rl0 = 4; rl1 = 7;
      for (int i = 0; i < 900; i++) begin
         for (int c = 0; c < N_CH; c++) begin
            rs[c] = ($urandom_range(0, 11) == 0);
            rr[c] = ($urandom_range(0, 19) == 0);
         end
         if ($urandom_range(0, 39) == 0) rr = 2'b11;
         if ($urandom_range(0, 24) == 0) rd = ~rd;
         if ($urandom_range(0, 15) == 0) rl0 = $urandom_range(0, 15);
         if ($urandom_range(0, 15) == 0) rl1 = $urandom_range(0, 15);
         drive(rs, rr, rd, rl0, rl1);
      end

      // asynchronous reset mid-RUN with mag_on high
      drive(2'b00, 2'b11, 0, 10, 10);
      drive(2'b11, 2'b00, 0, 10, 10);
      idle(4, 0, 10, 10);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async rst");
      bus1.set = '0; bus1.reset = '0; bus0.set = '0; bus0.reset = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      idle(3, 0, 0, 0);
      drive(2'b01, 2'b00, 0, 2, 0);
      idle(12, 0, 2, 0);

      repeat (3) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
